// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions used by the fetch stage and decode.
package rv32i_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } fetch_pkt_t;

  // A fetch address is legal only if it is word aligned.
  function automatic logic is_aligned(input logic [1:0] addr_lo);
    return addr_lo == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry hold slot between instr_mem response and decode.
// Parks a response that decode did not accept so the read is not lost.
module fetch_skid_buf #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_instr_i,
  input  logic [W-1:0] in_pc_i,
  input  logic         out_ready_i,
  output logic         hold_valid_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_instr_o,
  output logic [W-1:0] out_pc_o
);

  logic         hold_valid_q;
  logic [W-1:0] hold_instr_q;
  logic [W-1:0] hold_pc_q;

  // Hold slot: flush wins, drain on ready, capture an unaccepted response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else if (flush_i) begin
      hold_valid_q <= 1'b0;
    end else if (hold_valid_q && out_ready_i) begin
      hold_valid_q <= 1'b0;
    end else if (in_valid_i && !out_ready_i && !hold_valid_q) begin
      hold_valid_q <= 1'b1;
      hold_instr_q <= in_instr_i;
      hold_pc_q    <= in_pc_i;
    end
  end

  // Output mux: the parked entry is older, so it always goes first.
  always_comb begin
    out_valid_o = hold_valid_q | in_valid_i;
    if (hold_valid_q) begin
      out_instr_o = hold_instr_q;
      out_pc_o    = hold_pc_q;
    end else begin
      out_instr_o = in_instr_i;
      out_pc_o    = in_pc_i;
    end
  end

  assign hold_valid_o = hold_valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rv32i instruction-fetch stage: owns the PC, drives instr_mem, absorbs its
// one-cycle read latency and hands {instr, pc, pc+4} to decode.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc4,
  output logic            fetch_fault
);

  import rv32i_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic            resp_pending_q, resp_pending_d;
  logic            fault_q, fault_d;

  logic            fetching;
  logic            redirect;
  logic            issue;
  logic            hold_valid;
  logic            skid_valid;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;

  assign fetching = (state_q == FETCH);
  assign redirect = fetching & redirect_valid;
  assign issue    = fetching & ~redirect_valid &
                    (~(hold_valid | resp_pending_q) | out_ready);

  fetch_skid_buf #(
    .W (XLEN)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect),
    .in_valid_i   (resp_pending_q),
    .in_instr_i   (imem_rdata),
    .in_pc_i      (resp_pc_q),
    .out_ready_i  (out_ready),
    .hold_valid_o (hold_valid),
    .out_valid_o  (skid_valid),
    .out_instr_o  (skid_instr),
    .out_pc_o     (skid_pc)
  );

  // Next-state: redirect beats issue; a misaligned target parks the unit in FAULT.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    resp_pc_d      = resp_pc_q;
    resp_pending_d = 1'b0;
    fault_d        = fault_q;
    if (redirect) begin
      pc_d = redirect_target;
      if (!is_aligned(redirect_target[1:0])) begin
        state_d = FAULT;
        fault_d = 1'b1;
      end
    end else if (issue) begin
      pc_d           = pc_q + XLEN'(INSTR_BYTES);
      resp_pending_d = 1'b1;
      resp_pc_d      = pc_q;
    end
  end

  // PC, in-flight response tracking and fault state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      resp_pc_q      <= '0;
      resp_pending_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      resp_pc_q      <= resp_pc_d;
      resp_pending_q <= resp_pending_d;
      fault_q        <= fault_d;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_req    = issue;
  assign out_valid   = skid_valid & ~redirect_valid & fetching;
  assign out_instr   = skid_instr;
  assign out_pc      = skid_pc;
  assign out_pc4     = skid_pc + XLEN'(INSTR_BYTES);
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency instr_mem model
// returning addr/4 as the instruction word.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic        fetch_fault;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_req        (imem_req),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pc4         (out_pc4),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always_ff @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr >> 2;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic chk_pkt(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, out_instr, pc >> 2);
    chk({tag, "_pc4"}, out_pc4, pc + 32'd4);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    next_cycle();
    rst = 1'b0;
    settle();
    chk("c0_req", {31'b0, imem_req}, 32'd1);
    chk("c0_addr", imem_addr, 32'd0);
    chk("c0_valid", {31'b0, out_valid}, 32'd0);

    // Streaming with out_ready high
    for (int k = 1; k <= 3; k++) begin
      next_cycle(); settle();
      chk("stream_addr", imem_addr, 32'(4 * k));
      chk("stream_req", {31'b0, imem_req}, 32'd1);
      chk_pkt("stream", 32'(4 * (k - 1)));
    end

    // Stall for 3 cycles while pc 8 is presented
    out_ready = 1'b0;
    settle();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin next_cycle(); settle(); end
      chk_pkt("stall", 32'd8);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_addr", imem_addr, 32'd12);
    end
    next_cycle();
    out_ready = 1'b1;
    settle();
    chk_pkt("release_hold", 32'd8);
    chk("release_req", {31'b0, imem_req}, 32'd1);
    chk("release_addr", imem_addr, 32'd12);
    next_cycle(); settle();
    chk_pkt("release_next", 32'd12);

    // Redirect to 24 while pc 12 is presented
    redirect_valid = 1'b1; redirect_target = 32'd24;
    settle();
    chk("redir_valid", {31'b0, out_valid}, 32'd0);
    chk("redir_req", {31'b0, imem_req}, 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    settle();
    chk("redir_addr", imem_addr, 32'd24);
    chk("redir_req1", {31'b0, imem_req}, 32'd1);
    chk("redir_gap", {31'b0, out_valid}, 32'd0);
    next_cycle(); settle();
    chk_pkt("redir_tgt", 32'd24);

    // Repeated redirects 24 -> 8; stream 8..20 in between
    for (int r = 0; r < 3; r++) begin
      redirect_valid = 1'b1; redirect_target = 32'd8;
      settle();
      chk("loop_mask", {31'b0, out_valid}, 32'd0);
      next_cycle();
      redirect_valid = 1'b0;
      settle();
      chk("loop_addr", imem_addr, 32'd8);
      chk("loop_gap", {31'b0, out_valid}, 32'd0);
      for (int k = 0; k < 5; k++) begin
        next_cycle(); settle();
        if (k < 4) begin
          chk_pkt("loop", 32'(8 + 4 * k));
          chk("loop_addr_n", imem_addr, 32'(12 + 4 * k));
        end else begin
          chk("loop_pc24", out_pc, 32'd24);
        end
      end
    end

    // Misaligned redirect -> sticky fault
    redirect_valid = 1'b1; redirect_target = 32'h1A;
    settle();
    chk("flt_mask", {31'b0, out_valid}, 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    settle();
    chk("flt_fault", {31'b0, fetch_fault}, 32'd1);
    chk("flt_addr", imem_addr, 32'h1A);
    for (int k = 0; k < 20; k++) begin
      chk("flt_quiet", {30'b0, imem_req, out_valid}, 32'd0);
      next_cycle(); settle();
    end
    redirect_valid = 1'b1; redirect_target = 32'd0;
    settle();
    chk("flt_ign_req", {31'b0, imem_req}, 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    settle();
    chk("flt_ign_addr", imem_addr, 32'h1A);
    chk("flt_ign_fault", {31'b0, fetch_fault}, 32'd1);
    chk("flt_ign_valid", {31'b0, out_valid}, 32'd0);

    // Async reset mid-stall with the hold slot occupied
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    settle();
    chk("r2_addr", imem_addr, 32'd0);
    chk("r2_fault", {31'b0, fetch_fault}, 32'd0);
    next_cycle();
    out_ready = 1'b0;
    settle();
    chk_pkt("r2_pend", 32'd0);
    next_cycle(); settle();
    chk_pkt("r2_hold", 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd1);
    chk("arst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("arst_valid2", {31'b0, out_valid}, 32'd0);

    // Wrap from FFFF_FFFC to 0
    next_cycle();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF8;
    settle();
    next_cycle();
    redirect_valid = 1'b0;
    settle();
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    chk("wrap_req0", {31'b0, imem_req}, 32'd1);
    next_cycle(); settle();
    chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    chk_pkt("wrap_p0", 32'hFFFF_FFF8);
    next_cycle(); settle();
    chk("wrap_addr2", imem_addr, 32'h0000_0000);
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", out_pc4, 32'h0000_0000);
    chk("wrap_fault", {31'b0, fetch_fault}, 32'd0);
    next_cycle(); settle();
    chk_pkt("wrap_p2", 32'h0000_0000);
    chk("wrap_addr3", imem_addr, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
